// File: rtl/vga_reg_snapshot.sv
// vga_reg_snapshot: double-buffered snapshot of the CPU register file for the
// VGA debug screen. A vsync start edge triggers a scan of REG_NUM registers
// into the back bank; a one-cycle swap then makes it the displayed front bank,
// so the screen never shows a half-updated image.
// Optional feature macro: VGA_SNAPSHOT_DIFF_EN (per-register change flags).
module vga_reg_snapshot #(
   parameter int VSYNC_POL = 0,
   parameter int REG_NUM   = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        vsync,
   input  logic        freeze,
   output logic [4:0]  scan_addr,
   input  logic [31:0] scan_data,
   input  logic [4:0]  regAddr,
   output logic [31:0] regData,
   output logic        busy,
   output logic [15:0] snap_cnt,
   output logic [31:0] changed
);

   localparam logic       ACTIVE_LVL = (VSYNC_POL != 0);
   localparam logic [4:0] LAST_ADDR  = 5'(REG_NUM - 1);
   localparam logic [5:0] REG_LIMIT  = 6'(REG_NUM);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      SWAP = 2'd2
   } state_t;

   state_t      state_reg;
   state_t      state_next;
   logic        vsync_d_reg;
   logic        start_edge;
   logic        bank_ptr_reg;
   logic [4:0]  scan_addr_reg;
   logic [15:0] snap_cnt_reg;
   logic        scan_en;
   logic        swap_en;
   logic [31:0] front_word [32];

   // A start edge is vsync arriving at its active level from the opposite one.
   assign start_edge = (vsync == ACTIVE_LVL) && (vsync_d_reg != ACTIVE_LVL);

   // One-cycle delayed copy of vsync for edge detection
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vsync_d_reg <= 1'b0;
      end else begin
         vsync_d_reg <= vsync;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next state: edges during SCAN/SWAP are simply dropped, never queued
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start_edge && !freeze) begin
               state_next = SCAN;
            end
         end
         SCAN: begin
            if (scan_addr_reg == LAST_ADDR) begin
               state_next = SWAP;
            end
         end
         SWAP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FSM outputs decoded from the current state
   always_comb begin
      busy    = (state_reg != IDLE);
      scan_en = (state_reg == SCAN);
      swap_en = (state_reg == SWAP);
   end

   // Scan address walks 0..REG_NUM-1 during SCAN and parks at 0 otherwise
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         scan_addr_reg <= 5'd0;
      end else if (scan_en) begin
         scan_addr_reg <= scan_addr_reg + 5'd1;
      end else if (swap_en) begin
         scan_addr_reg <= 5'd0;
      end
   end

   // Bank pointer flips and snapshot counter advances only on the swap cycle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bank_ptr_reg <= 1'b0;
         snap_cnt_reg <= 16'd0;
      end else if (swap_en) begin
         bank_ptr_reg <= ~bank_ptr_reg;
         snap_cnt_reg <= snap_cnt_reg + 16'd1;
      end
   end

   assign scan_addr = scan_addr_reg;
   assign snap_cnt  = snap_cnt_reg;

   // Storage is flop-based: both banks must clear asynchronously on reset.
   // Bank 0 is the front when bank_ptr_reg = 0, so the scan writes bank 1.
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_reg
         logic [31:0] bank0_reg;
         logic [31:0] bank1_reg;
         logic        wr_hit;

         assign wr_hit = scan_en && (scan_addr_reg == 5'(gi));

         // Back-bank write of register gi when the scan reaches it
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               bank0_reg <= 32'h0;
               bank1_reg <= 32'h0;
            end else if (wr_hit) begin
               if (bank_ptr_reg) begin
                  bank0_reg <= scan_data;
               end else begin
                  bank1_reg <= scan_data;
               end
            end
         end

         assign front_word[gi] = bank_ptr_reg ? bank1_reg : bank0_reg;
      end
   endgenerate

   // Display read: front bank only, so it can change only when the pointer flips
   assign regData = ({1'b0, regAddr} >= REG_LIMIT) ? 32'h0 : front_word[regAddr];

`ifdef VGA_SNAPSHOT_DIFF_EN
   logic [31:0] diff_vec;
   logic [31:0] changed_reg;

   generate
      for (gi = 0; gi < 32; gi++) begin : g_diff
         logic diff_bit_reg;

         // Compare the incoming value with the currently displayed one
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               diff_bit_reg <= 1'b0;
            end else if (g_reg[gi].wr_hit) begin
               diff_bit_reg <= (scan_data != front_word[gi]);
            end
         end

         assign diff_vec[gi] = diff_bit_reg;
      end
   endgenerate

   // Publish the change flags together with the new front bank
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         changed_reg <= 32'h0;
      end else if (swap_en) begin
         changed_reg <= diff_vec;
      end
   end

   assign changed = changed_reg;
`else
   assign changed = 32'h0;
`endif

endmodule

// File: tb/tb_vga_reg_snapshot.sv
// Directed bench for vga_reg_snapshot: a default instance (REG_NUM=32) and a
// REG_NUM=16 instance, driven from a shared model register file.
module tb_vga_reg_snapshot;

   logic        clk = 1'b0;
   logic        resetn;
   logic        vsync, vsync16;
   logic        freeze, freeze16;
   logic [4:0]  scan_addr, scan_addr16;
   logic [31:0] scan_data, scan_data16;
   logic [4:0]  regAddr, regAddr16;
   logic [31:0] regData, regData16;
   logic        busy, busy16;
   logic [15:0] snap_cnt, snap_cnt16;
   logic [31:0] changed, changed16;

   logic [31:0] rf [32];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n;
   logic [31:0] mid;
   logic [31:0] exp_changed;

   always #5 clk = ~clk;

   assign scan_data   = rf[scan_addr];
   assign scan_data16 = rf[scan_addr16];

   vga_reg_snapshot dut (
      .clk       (clk),
      .resetn    (resetn),
      .vsync     (vsync),
      .freeze    (freeze),
      .scan_addr (scan_addr),
      .scan_data (scan_data),
      .regAddr   (regAddr),
      .regData   (regData),
      .busy      (busy),
      .snap_cnt  (snap_cnt),
      .changed   (changed)
   );

   vga_reg_snapshot #(.REG_NUM(16)) dut16 (
      .clk       (clk),
      .resetn    (resetn),
      .vsync     (vsync16),
      .freeze    (freeze16),
      .scan_addr (scan_addr16),
      .scan_data (scan_data16),
      .regAddr   (regAddr16),
      .regData   (regData16),
      .busy      (busy16),
      .snap_cnt  (snap_cnt16),
      .changed   (changed16)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end else begin
         $display("ok   %s: %08h", tag, got);
      end
   endtask

   task automatic fill_rf(input logic [31:0] base);
      for (int i = 0; i < 32; i++) rf[i] = base + 32'(i);
   endtask

   // One vsync pulse, then count busy cycles (bounded). Optionally inject a
   // second edge or raise freeze at a given busy cycle; sample regData at cycle 20.
   task automatic snap(input bit s16, input int inj, input int frz,
                       output int cnt, output logic [31:0] mid_data);
      @(negedge clk);
      if (s16) vsync16 = 1'b0; else vsync = 1'b0;
      @(negedge clk);
      vsync = 1'b1; vsync16 = 1'b1;
      cnt = 0;
      mid_data = 32'h0;
      while ((s16 ? busy16 : busy) && cnt < 100) begin
         cnt++;
         if (cnt == 20) mid_data = s16 ? regData16 : regData;
         if (inj != 0 && cnt == inj) begin
            if (s16) vsync16 = 1'b0; else vsync = 1'b0;
         end else begin
            vsync = 1'b1; vsync16 = 1'b1;
         end
         if (frz != 0 && cnt == frz) freeze = 1'b1;
         @(negedge clk);
      end
      vsync = 1'b1; vsync16 = 1'b1;
   endtask

   initial begin
      resetn = 1'b0; vsync = 1'b1; vsync16 = 1'b1;
      freeze = 1'b0; freeze16 = 1'b0;
      regAddr = 5'd5; regAddr16 = 5'd0;
      fill_rf(32'h1000_0000);
      repeat (3) @(negedge clk);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_snap_cnt", 32'(snap_cnt), 32'd0);
      check_val("rst_regdata", regData, 32'h0);
      check_val("rst_scan_addr", 32'(scan_addr), 32'd0);
      check_val("rst_changed", changed, 32'h0);
      resetn = 1'b1;
      repeat (3) @(negedge clk);

      // First snapshot
      snap(1'b0, 0, 0, n, mid);
      check_val("snap1_busy_cycles", 32'(n), 32'd33);
      check_val("snap1_cnt", 32'(snap_cnt), 32'd1);
      check_val("snap1_reg5", regData, 32'h1000_0005);
      regAddr = 5'd31; #1;
      check_val("snap1_reg31", regData, 32'h1000_001F);
      regAddr = 5'd5;

      // Second edge mid-scan ignored; regData stays on old image until swap
      fill_rf(32'h2000_0000);
      snap(1'b0, 10, 0, n, mid);
      check_val("snap2_busy_cycles", 32'(n), 32'd33);
      check_val("snap2_mid_regdata", mid, 32'h1000_0005);
      check_val("snap2_cnt", 32'(snap_cnt), 32'd2);
      check_val("snap2_reg5", regData, 32'h2000_0005);
      repeat (3) @(negedge clk);
      check_val("snap2_not_queued", 32'(busy), 32'd0);

      // Freeze at the edge: no scan
      fill_rf(32'h3000_0000);
      freeze = 1'b1;
      snap(1'b0, 0, 0, n, mid);
      check_val("frz_edge_busy_cycles", 32'(n), 32'd0);
      check_val("frz_edge_cnt", 32'(snap_cnt), 32'd2);
      check_val("frz_edge_reg5", regData, 32'h2000_0005);
      freeze = 1'b0;
      @(negedge clk);

      // Freeze mid-scan: scan completes
      snap(1'b0, 0, 5, n, mid);
      check_val("frz_mid_busy_cycles", 32'(n), 32'd33);
      check_val("frz_mid_cnt", 32'(snap_cnt), 32'd3);
      check_val("frz_mid_reg5", regData, 32'h3000_0005);
      freeze = 1'b0;

      // Reset at SCAN cycle 16
      @(negedge clk); vsync = 1'b0;
      @(negedge clk); vsync = 1'b1;
      repeat (15) @(negedge clk);
      check_val("pre_rst_busy", 32'(busy), 32'd1);
      resetn = 1'b0;
      #1;
      check_val("mid_rst_busy", 32'(busy), 32'd0);
      check_val("mid_rst_regdata", regData, 32'h0);
      check_val("mid_rst_cnt", 32'(snap_cnt), 32'd0);
      @(negedge clk); resetn = 1'b1;
      repeat (3) @(negedge clk);
      check_val("post_rst_cnt", 32'(snap_cnt), 32'd0);
      snap(1'b0, 0, 0, n, mid);
      check_val("post_rst_busy_cycles", 32'(n), 32'd33);
      check_val("post_rst_cnt1", 32'(snap_cnt), 32'd1);
      check_val("post_rst_reg5", regData, 32'h3000_0005);

      // Change flags: only r[3] differs between the last two snapshots
      for (int i = 0; i < 32; i++) rf[i] = 32'h55;
      rf[3] = 32'hA;
      snap(1'b0, 0, 0, n, mid);
      rf[3] = 32'hB;
      snap(1'b0, 0, 0, n, mid);
`ifdef VGA_SNAPSHOT_DIFF_EN
      exp_changed = 32'h0000_0008;
`else
      exp_changed = 32'h0;
`endif
      check_val("diff_changed", changed, exp_changed);
      regAddr = 5'd3; #1;
      check_val("diff_reg3", regData, 32'hB);
      check_val("diff_cnt", 32'(snap_cnt), 32'd3);

      // REG_NUM = 16 instance
      snap(1'b1, 0, 0, n, mid);
      check_val("r16_busy_cycles", 32'(n), 32'd17);
      check_val("r16_cnt", 32'(snap_cnt16), 32'd1);
      regAddr16 = 5'd15; #1;
      check_val("r16_reg15", regData16, 32'h55);
      regAddr16 = 5'd20; #1;
      check_val("r16_reg20", regData16, 32'h0);
      force dut16.snap_cnt_reg = 16'hFFFF;
      @(negedge clk);
      release dut16.snap_cnt_reg;
      @(negedge clk);
      check_val("r16_forced_cnt", 32'(snap_cnt16), 32'h0000_FFFF);
      snap(1'b1, 0, 0, n, mid);
      check_val("r16_wrap_busy_cycles", 32'(n), 32'd17);
      check_val("r16_wrap_cnt", 32'(snap_cnt16), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
